instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch/sequencer feeding instr_decoder. Reads 32-bit words from instruction memory at PC.
//  Issues each word to the decoder as one long instruction (bit31=1) or two short halves (upper, then lower).
//  Stalls issue after a short jump until execute resolves it, then redirects or continues.
//  Outputs are stable at negedge for the decoder.
// PARAMETERS
//  WIDTH       32  instruction word width
//  ADDR_WIDTH  16  word-address width of instruction memory
//  RESET_PC    0   word address fetched first after reset
// PORTS
//  clk          in   1           system clock; all state changes on posedge
//  rst_n        in   1           asynchronous, active-low reset
//  stall        in   1           hold issue/request (backpressure from core)
//  imem_rd      out  1           read strobe; data returned on imem_data the following cycle
//  imem_addr    out  ADDR_WIDTH  word address of read
//  imem_data    in   WIDTH       read data, valid exactly one cycle after imem_rd
//  br_done      in   1           one-cycle pulse: pending jump resolved by execute
//  br_taken     in   1           qualifies br_done: 1 = redirect to br_target
//  br_target    in   ADDR_WIDTH  word address of jump target
//  dec_en       out  1           to decoder en; high one cycle per issued instruction
//  long_instr   out  WIDTH       held instruction word to decoder
//  instr_choose out  1           0 = upper half, 1 = lower half (ignored for long words)
//  pc           out  ADDR_WIDTH  word address of word currently held
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr word=0. All outputs 0 except pc.
//  States. All outputs decode registered state/regs only.
//   IDLE: outputs 0. Next state REQ.
//   REQ: imem_rd=1, imem_addr=pc. If stall, imem_rd=0 and stay in REQ. Otherwise go to DATA.
//   DATA: capture imem_data into the word register, regardless of stall. Next state ISSUE0.
//   ISSUE0: long_instr=word, instr_choose=0, dec_en=!stall. Hold while stalled. On issue:
//    - word[31]=1 (long): pc<=pc+1 mod 2^ADDR_WIDTH, then REQ.
//    - upper half is a jump: go to BRWAIT (half=0).
//    - otherwise: go to ISSUE1.
//   ISSUE1: instr_choose=1, dec_en=!stall. Hold while stalled. On issue:
//    - lower half is a jump: go to BRWAIT (half=1).
//    - otherwise: pc<=pc+1, then REQ.
//   BRWAIT: dec_en=0; waits indefinitely. On br_done:
//    - br_taken: pc<=br_target, then REQ. The lower half is discarded.
//    - not taken, half=0: go to ISSUE1.
//    - not taken, half=1: pc<=pc+1, then REQ.
//  Jump detect (16-bit half h): h[15]=0, h[14]=0, h[13:9] in 5'b01001..5'b01111.
//   Long words are never jumps.
//  br_done outside BRWAIT is ignored. br_taken is sampled only with br_done.
//  stall has no effect in IDLE, DATA or BRWAIT. br_done is still accepted in BRWAIT while stalled.
//  Cadence with no stall: long word = 3 cycles, short pair = 4 cycles.
//  long_instr is held constant from DATA until the next DATA capture.
//  pc wraps modulo 2^ADDR_WIDTH; br_target is used verbatim.
//  Reset mid-operation (any state): immediately back to IDLE and RESET_PC.
//   An in-flight read is discarded and dec_en drops asynchronously.
// TESTING
//  1. Reset release, mem[0]=32'h8400_1234 (long).
//     -> imem_rd with addr 0 on 2nd posedge cycle.
//     -> one dec_en with long_instr=32'h8400_1234 and choose=0.
//     -> next imem_rd addr 1.
//  2. mem[1]=32'h4123_4456 (short pair).
//     -> dec_en choose=0, then choose=1 on the next cycle.
//     -> 4-cycle spacing to the next read of addr 2.
//  3. mem[2]=32'h1E00_0000 (upper jump).
//     -> one dec_en, then dec_en=0 for 5 cycles.
//     -> br_done=1, br_taken=1, br_target=16'h0040: lower half never issued; next imem_addr=16'h0040.
//  4. mem[0x40]=32'h4000_1200 (lower jump).
//     -> br_done with br_taken=0: next imem_addr=16'h0041.
//     -> br_done pulsed while in ISSUE0 is ignored.
//  5. stall=1 for 3 cycles in ISSUE1.
//     -> dec_en stays 0 and choose stays 1; issues on the first cycle after stall drops.
//     -> stall in REQ: imem_rd=0 until released.
//  6. rst_n low while in BRWAIT with pc=16'h0041.
//     -> all outputs 0 and pc=RESET_PC immediately.
//     -> fetch restarts at addr 0; a later br_done is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: reads words from instruction memory and issues them
// to the decoder as one long instruction or as two short halves, pausing on jumps.
module instr_fetch #(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  output logic                  imem_rd,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0]      imem_data,
  input  logic                  br_done,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  dec_en,
  output logic [WIDTH-1:0]      long_instr,
  output logic                  instr_choose,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int HW = WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    DATA   = 3'd2,
    ISSUE0 = 3'd3,
    ISSUE1 = 3'd4,
    BRWAIT = 3'd5
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_next;
  logic [WIDTH-1:0]        word_q, word_next;
  logic                    half_q, half_next;

  // A short half is a jump when its two top bits are clear and its opcode field is 9..15
  function automatic logic is_jump(input logic [HW-1:0] h);
    return (h[HW-1:HW-2] == 2'b00) &&
           (h[HW-3:HW-7] >= 5'd9) && (h[HW-3:HW-7] <= 5'd15);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      word_q <= '0;
      half_q <= 1'b0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      word_q <= word_next;
      half_q <= half_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc_q;
    word_next    = word_q;
    half_next    = half_q;
    imem_rd      = 1'b0;
    imem_addr    = '0;
    dec_en       = 1'b0;
    instr_choose = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_addr = pc_q;
        if (!stall) begin
          imem_rd    = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        word_next  = imem_data;
        state_next = ISSUE0;
      end
      ISSUE0: begin
        dec_en = !stall;
        if (!stall) begin
          if (word_q[WIDTH-1]) begin
            pc_next    = pc_q + ADDR_WIDTH'(1);
            state_next = REQ;
          end else if (is_jump(word_q[WIDTH-1:HW])) begin
            half_next  = 1'b0;
            state_next = BRWAIT;
          end else begin
            state_next = ISSUE1;
          end
        end
      end
      ISSUE1: begin
        instr_choose = 1'b1;
        dec_en       = !stall;
        if (!stall) begin
          if (is_jump(word_q[HW-1:0])) begin
            half_next  = 1'b1;
            state_next = BRWAIT;
          end else begin
            pc_next    = pc_q + ADDR_WIDTH'(1);
            state_next = REQ;
          end
        end
      end
      BRWAIT: begin
        // A taken jump discards any lower half still pending in the held word
        if (br_done) begin
          if (br_taken) begin
            pc_next    = br_target;
            state_next = REQ;
          end else if (!half_q) begin
            state_next = ISSUE1;
          end else begin
            pc_next    = pc_q + ADDR_WIDTH'(1);
            state_next = REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign long_instr = word_q;
  assign pc         = pc_q;

endmodule
